// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single off-chip block memory port between the I-cache and D-cache engines.
// One transaction at a time; completion is routed only to the owner; sticky hung-memory watchdog.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantD, StDone} state_e;

  localparam logic [7:0] Tmo = 8'(TIMEOUT);

  state_e     state;
  logic       last_grant;
  logic [7:0] wcnt;
  logic       req_i;
  logic       req_d;
  logic       win_d;

  always_comb begin
    req_i = i_read;
    req_d = d_read | d_write;
    // Tie goes to D in priority mode, otherwise to whoever was not served last.
    win_d = req_d & (~req_i | (PRIO_MODE != 0) | ~last_grant);
  end

  assign i_ready = (state == StGrantI) & mem_ready;
  assign d_ready = (state == StGrantD) & mem_ready;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      last_grant <= 1'b0;
      wcnt       <= 8'd0;
      err        <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (win_d) begin
            state     <= StGrantD;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_write <= d_write;
            mem_read  <= ~d_write;
          end else if (req_i) begin
            state     <= StGrantI;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
          end
        end
        StGrantI, StGrantD: begin
          if (mem_ready) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            last_grant <= (state == StGrantD);
            wcnt       <= 8'd0;
            state      <= StDone;
          end else if (wcnt != 8'hFF) begin
            // Transaction keeps waiting; the flag only reports the hang.
            wcnt <= wcnt + 8'd1;
            if (wcnt + 8'd1 == Tmo) err <= 1'b1;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a round-robin instance (TIMEOUT=4) and a D-priority
// instance share all inputs; each task checks one behaviour.
module tb_cache_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam logic [DW-1:0] RdA5 = {16{8'hA5}};
  localparam logic [DW-1:0] Wd   = 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;

  logic a_i_ready, a_d_ready, a_mem_read, a_mem_write, a_err;
  logic b_i_ready, b_d_ready, b_mem_read, b_mem_write, b_err;
  logic [DW-1:0] a_i_rdata, a_d_rdata, a_mem_wdata, b_i_rdata, b_d_rdata, b_mem_wdata;
  logic [AW-1:0] a_mem_addr, b_mem_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .i_read(i_read), .i_addr(i_addr), .i_ready(a_i_ready),
    .i_rdata(a_i_rdata), .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(a_d_ready), .d_rdata(a_d_rdata), .mem_read(a_mem_read),
    .mem_write(a_mem_write), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(a_err)
  );

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1), .TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst), .i_read(i_read), .i_addr(i_addr), .i_ready(b_i_ready),
    .i_rdata(b_i_rdata), .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(b_d_ready), .d_rdata(b_d_rdata), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(b_err)
  );

  task automatic do_reset();
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Stimulus only: waits for a command, holds mem_ready off for lat cycles, then acks.
  // Returns with the DUT in DONE, just after the edge. gap = -1 means no command appeared.
  task automatic run_txn(input bit use_b, input int lat, input logic [DW-1:0] rd,
                         output int gap, output logic cr, output logic cw,
                         output logic [AW-1:0] ca, output logic [DW-1:0] cwd,
                         output logic ri, output logic rdd, output logic [DW-1:0] rdo);
    logic cmd;
    cmd = 1'b0; gap = 0; cr = 1'b0; cw = 1'b0; ca = '0; cwd = '0; ri = 1'b0; rdd = 1'b0; rdo = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cmd = use_b ? (b_mem_read | b_mem_write) : (a_mem_read | a_mem_write);
      if (cmd) break;
      gap++;
    end
    if (!cmd) begin
      gap = -1;
      return;
    end
    cr  = use_b ? b_mem_read  : a_mem_read;
    cw  = use_b ? b_mem_write : a_mem_write;
    ca  = use_b ? b_mem_addr  : a_mem_addr;
    cwd = use_b ? b_mem_wdata : a_mem_wdata;
    repeat (lat) @(negedge clk);
    mem_ready = 1'b1; mem_rdata = rd;
    #1;
    ri  = use_b ? b_i_ready : a_i_ready;
    rdd = use_b ? b_d_ready : a_d_ready;
    rdo = use_b ? (b_d_ready ? b_d_rdata : b_i_rdata) : (a_d_ready ? a_d_rdata : a_i_rdata);
    @(posedge clk);
    #1 mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++; if ({a_mem_read, a_mem_write, a_err} !== 3'b000) begin miscompares++;
      $display("FAIL reset_ctl: got %b want 000", {a_mem_read, a_mem_write, a_err}); end
    vectors++; if ({a_mem_addr, a_mem_wdata} !== '0) begin miscompares++;
      $display("FAIL reset_bus: got %h/%h want 0", a_mem_addr, a_mem_wdata); end
    // mem_ready while idle must be ignored
    mem_ready = 1'b1; mem_rdata = RdA5;
    #1;
    vectors++; if ({a_i_ready, a_d_ready} !== 2'b00) begin miscompares++;
      $display("FAIL idle_ready: got %b want 00", {a_i_ready, a_d_ready}); end
    @(negedge clk);
    mem_ready = 1'b0;
    vectors++; if ({a_mem_read, a_mem_write} !== 2'b00) begin miscompares++;
      $display("FAIL idle_nocmd: got %b want 00", {a_mem_read, a_mem_write}); end
  endtask

  task automatic test_single_read();
    int gap; logic cr, cw, ri, rdd; logic [AW-1:0] ca; logic [DW-1:0] cwd, rdo;
    do_reset();
    i_addr = 28'h0000010; i_read = 1'b1;
    run_txn(0, 5, RdA5, gap, cr, cw, ca, cwd, ri, rdd, rdo);
    vectors++; if (gap !== 1) begin miscompares++;
      $display("FAIL rd_latency: got %0d want 1", gap); end
    vectors++; if ({cr, cw} !== 2'b10) begin miscompares++;
      $display("FAIL rd_cmd: got %b want 10", {cr, cw}); end
    vectors++; if (ca !== 28'h0000010 || cwd !== '0) begin miscompares++;
      $display("FAIL rd_addr: got %h/%h want 0000010/0", ca, cwd); end
    vectors++; if ({ri, rdd} !== 2'b10 || rdo !== RdA5) begin miscompares++;
      $display("FAIL rd_done: got %b %h want 10 %h", {ri, rdd}, rdo, RdA5); end
    i_read = 1'b0;
    @(negedge clk);
    vectors++; if ({a_i_ready, a_mem_read} !== 2'b00) begin miscompares++;
      $display("FAIL rd_pulse: got %b want 00", {a_i_ready, a_mem_read}); end
  endtask

  task automatic test_write_back();
    int gap; logic cr, cw, ri, rdd; logic [AW-1:0] ca; logic [DW-1:0] cwd, rdo;
    do_reset();
    d_addr = 28'h0ABCDEF; d_wdata = Wd; d_write = 1'b1; d_read = 1'b1;
    run_txn(0, 3, '0, gap, cr, cw, ca, cwd, ri, rdd, rdo);
    vectors++; if ({cr, cw} !== 2'b01) begin miscompares++;
      $display("FAIL wb_cmd: got %b want 01", {cr, cw}); end
    vectors++; if (ca !== 28'h0ABCDEF || cwd !== Wd) begin miscompares++;
      $display("FAIL wb_bus: got %h/%h want 0abcdef/%h", ca, cwd, Wd); end
    vectors++; if ({ri, rdd} !== 2'b01) begin miscompares++;
      $display("FAIL wb_ready: got %b want 01", {ri, rdd}); end
    d_write = 1'b0; d_read = 1'b0;
    @(negedge clk);
    vectors++; if ({a_d_ready, a_mem_write} !== 2'b00) begin miscompares++;
      $display("FAIL wb_pulse: got %b want 00", {a_d_ready, a_mem_write}); end
  endtask

  task automatic test_round_robin();
    int gap; logic cr, cw, ri, rdd; logic [AW-1:0] ca; logic [DW-1:0] cwd, rdo;
    logic want_d;
    do_reset();
    i_addr = 28'h1111111; d_addr = 28'h2222222; d_wdata = Wd; i_read = 1'b1; d_read = 1'b1;
    for (int t = 0; t < 4; t++) begin
      want_d = (t % 2 == 0);
      run_txn(0, 1, '0, gap, cr, cw, ca, cwd, ri, rdd, rdo);
      vectors++; if (ca !== (want_d ? 28'h2222222 : 28'h1111111) || {ri, rdd} !== {~want_d, want_d})
        begin miscompares++;
        $display("FAIL rr_owner%0d: got %h %b want d=%b", t, ca, {ri, rdd}, want_d); end
      vectors++; if (cwd !== (want_d ? Wd : '0)) begin miscompares++;
        $display("FAIL rr_wdata%0d: got %h", t, cwd); end
      if (t > 0) begin
        vectors++; if (gap < 2) begin miscompares++;
          $display("FAIL rr_gap%0d: got %0d want >=2", t, gap); end
      end
    end
    i_read = 1'b0; d_read = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_d_priority();
    int gap; logic cr, cw, ri, rdd; logic [AW-1:0] ca; logic [DW-1:0] cwd, rdo;
    do_reset();
    i_addr = 28'h1111111; d_addr = 28'h2222222; i_read = 1'b1; d_read = 1'b1;
    for (int t = 0; t < 3; t++) begin
      run_txn(1, 1, '0, gap, cr, cw, ca, cwd, ri, rdd, rdo);
      vectors++; if (ca !== 28'h2222222 || {ri, rdd} !== 2'b01) begin miscompares++;
        $display("FAIL prio_d%0d: got %h %b want 2222222 01", t, ca, {ri, rdd}); end
    end
    d_read = 1'b0;
    run_txn(1, 1, RdA5, gap, cr, cw, ca, cwd, ri, rdd, rdo);
    vectors++; if (ca !== 28'h1111111 || {ri, rdd} !== 2'b10) begin miscompares++;
      $display("FAIL prio_i: got %h %b want 1111111 10", ca, {ri, rdd}); end
    i_read = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_watchdog();
    logic found;
    do_reset();
    i_addr = 28'h0000033; i_read = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (a_mem_read) begin found = 1'b1; break; end
    end
    vectors++; if (found !== 1'b1) begin miscompares++;
      $display("FAIL wd_grant: got %b want 1", found); end
    vectors++; if (a_err !== 1'b0) begin miscompares++;
      $display("FAIL wd_start: got %b want 0", a_err); end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3 || k == 4 || k == 10) begin
        vectors++; if (a_err !== (k >= 4)) begin miscompares++;
          $display("FAIL wd_err_k%0d: got %b want %b", k, a_err, (k >= 4)); end
      end
    end
    mem_ready = 1'b1; mem_rdata = RdA5;
    #1;
    vectors++; if ({a_i_ready, a_d_ready} !== 2'b10) begin miscompares++;
      $display("FAIL wd_late_ready: got %b want 10", {a_i_ready, a_d_ready}); end
    @(posedge clk);
    #1 mem_ready = 1'b0; i_read = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (a_err !== 1'b1 || a_mem_read !== 1'b0) begin miscompares++;
      $display("FAIL wd_sticky: got err=%b rd=%b want 1 0", a_err, a_mem_read); end
  endtask

  task automatic test_reset_mid_grant();
    int gap; logic cr, cw, ri, rdd; logic [AW-1:0] ca; logic [DW-1:0] cwd, rdo;
    logic found;
    do_reset();
    d_addr = 28'h0000044; d_read = 1'b1;
    run_txn(0, 0, '0, gap, cr, cw, ca, cwd, ri, rdd, rdo);
    d_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 d_addr = 28'h0000055; d_wdata = Wd; d_write = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (a_mem_write) begin found = 1'b1; break; end
    end
    repeat (6) @(negedge clk);
    vectors++; if ({found, a_err} !== 2'b11) begin miscompares++;
      $display("FAIL rst_pre: got %b want 11", {found, a_err}); end
    rst = 1'b1; d_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if ({a_mem_read, a_mem_write, a_err} !== 3'b000) begin miscompares++;
      $display("FAIL rst_ctl: got %b want 000", {a_mem_read, a_mem_write, a_err}); end
    vectors++; if ({a_mem_addr, a_mem_wdata} !== '0) begin miscompares++;
      $display("FAIL rst_bus: got %h/%h want 0", a_mem_addr, a_mem_wdata); end
    i_addr = 28'h0000066; d_addr = 28'h0000077; i_read = 1'b1; d_read = 1'b1;
    run_txn(0, 0, '0, gap, cr, cw, ca, cwd, ri, rdd, rdo);
    vectors++; if (ca !== 28'h0000077 || {ri, rdd} !== 2'b01 || {cr, cw} !== 2'b10) begin
      miscompares++;
      $display("FAIL rst_tie: got %h %b %b want 0000077 01 10", ca, {ri, rdd}, {cr, cw}); end
    i_read = 1'b0; d_read = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_back();
    test_round_robin();
    test_d_priority();
    test_watchdog();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

endmodule
